// File: rtl/sbm_mult_scheduler.sv
// Round-robin scheduler that time-shares one digit-serial multiplier core
// between NREQ requesters, with a watchdog that aborts a core that never finishes.
module sbm_mult_scheduler #(
  parameter int unsigned SIZEA   = 32,
  parameter int unsigned SIZEB   = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNTW    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*SIZEA-1:0]   req_a,
  input  logic [NREQ*SIZEB-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [SIZEA+SIZEB-1:0]  rsp_c,
  output logic                    rsp_err,
  input  logic                    rsp_ready,
  output logic                    mul_start,
  output logic [SIZEA-1:0]        mul_a,
  output logic [SIZEB-1:0]        mul_b,
  output logic                    mul_clr,
  input  logic                    mul_done,
  input  logic [SIZEA+SIZEB-1:0]  mul_c,
  output logic                    busy,
  output logic                    err_sticky
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_CLEAR} state_e;

  state_e                   state_q;
  logic [IDW-1:0]           ptr_q;
  logic [CNTW-1:0]          wd_q;
  logic                     rsp_valid_q;
  logic [IDW-1:0]           rsp_id_q;
  logic [SIZEA+SIZEB-1:0]   rsp_c_q;
  logic                     rsp_err_q;
  logic                     mul_start_q;
  logic [SIZEA-1:0]         mul_a_q;
  logic [SIZEB-1:0]         mul_b_q;
  logic                     mul_clr_q;
  logic                     err_sticky_q;

  logic                     win_vld_d;
  logic [IDW-1:0]           win_d;
  logic [IDW-1:0]           ptr_d;
  logic [SIZEA-1:0]         op_a_d;
  logic [SIZEB-1:0]         op_b_d;
  logic                     timeout_d;

  // Search from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] cand;
    win_vld_d = 1'b0;
    win_d     = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!win_vld_d && req_valid[cand]) begin
        win_vld_d = 1'b1;
        win_d     = cand;
      end
    end
  end

  always_comb begin
    ptr_d  = (32'(win_d) == NREQ - 1) ? '0 : win_d + IDW'(1);
    op_a_d = req_a[32'(win_d)*SIZEA +: SIZEA];
    op_b_d = req_b[32'(win_d)*SIZEB +: SIZEB];
  end

  // Gated by rst so the grant also reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst && (state_q == S_IDLE) && win_vld_d) req_ready[win_d] = 1'b1;
  end

  assign timeout_d = (wd_q == CNTW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      wd_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_c_q      <= '0;
      rsp_err_q    <= 1'b0;
      mul_start_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_clr_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      mul_clr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            mul_a_q     <= op_a_d;
            mul_b_q     <= op_b_d;
            rsp_id_q    <= win_d;
            ptr_q       <= ptr_d;
            mul_start_q <= 1'b1;
            wd_q        <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A done arriving on the timeout cycle still counts as success.
          if (mul_done) begin
            rsp_c_q     <= mul_c;
            rsp_err_q   <= 1'b0;
            mul_start_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (timeout_d) begin
            rsp_c_q      <= '0;
            rsp_err_q    <= 1'b1;
            err_sticky_q <= 1'b1;
            mul_start_q  <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            wd_q <= wd_q + CNTW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            mul_clr_q   <= 1'b1;
            state_q     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          wd_q    <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_err    = rsp_err_q;
  assign mul_start  = mul_start_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_clr    = mul_clr_q;
  assign busy       = (state_q != S_IDLE);
  assign err_sticky = err_sticky_q;

endmodule

// File: doc/sbm_mult_scheduler.md
Name: sbm_mult_scheduler

Overview:
- Shares one digit-serial multiplier core (sbm_digitized style: level start, done flag, local clear) between NREQ requesters.
- Round-robin arbitration; valid/ready handshake on request and response sides.
- Sequences the core: start, wait for done, capture product, return it tagged with requester id, clear the core.
- Watchdog flags a core that never asserts done.

Parameters:
- SIZEA, 32, operand A width
- SIZEB, 32, operand B width
- NREQ, 4, number of requesters
- IDW, 2, requester id width (clog2 of NREQ)
- TIMEOUT, 1023, max WAIT cycles before abort
- CNTW, 10, watchdog counter width (must hold TIMEOUT)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*SIZEA  packed operand A; requester i at [i*SIZEA +: SIZEA]
- req_b  in  NREQ*SIZEB  packed operand B, same packing
- req_ready  out  NREQ  one-hot grant; combinational, asserted only in IDLE
- rsp_valid  out  1  result valid
- rsp_id  out  IDW  requester id of the result
- rsp_c  out  SIZEA+SIZEB  product
- rsp_err  out  1  result aborted by watchdog; rsp_c is 0
- rsp_ready  in  1  consumer accepts result
- mul_start  out  1  core start, level, held until done
- mul_a  out  SIZEA  registered operand A to core
- mul_b  out  SIZEB  registered operand B to core
- mul_clr  out  1  one-cycle core clear pulse
- mul_done  in  1  core done
- mul_c  in  SIZEA+SIZEB  core product
- busy  out  1  state != IDLE
- err_sticky  out  1  set on any timeout; cleared only by reset

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; round-robin pointer 0; watchdog 0.
- IDLE:
  - Winner is the first requester with req_valid=1, searching from ptr upward with wrap (ptr, ptr+1, ... NREQ-1, 0, ...).
  - req_ready[winner]=1, all other bits 0. With no valid requests, req_ready=0.
  - On req_valid[w]&req_ready[w]: latch req_a/req_b slice into mul_a/mul_b and w into rsp_id; ptr <= w+1 mod NREQ; go to WAIT with mul_start=1 from the next cycle.
- WAIT:
  - mul_start held 1; watchdog increments each cycle.
  - mul_done=1: rsp_c <= mul_c, rsp_err <= 0, mul_start <= 0, rsp_valid <= 1, go to RESP.
  - Watchdog == TIMEOUT with no done: rsp_c <= 0, rsp_err <= 1, err_sticky <= 1, mul_start <= 0, rsp_valid <= 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid, rsp_id, rsp_c, rsp_err held stable until rsp_ready=1.
  - On rsp_ready=1: rsp_valid <= 0, go to CLEAR.
- CLEAR: mul_clr=1 for exactly one cycle; watchdog <= 0; go to IDLE.
- Latency:
  - Accept at cycle T; mul_start high from T+1.
  - Done seen at cycle D gives rsp_valid at D+1.
  - Minimum accept-to-accept period is core latency + 4 cycles with rsp_ready tied 1.
- Requests are not queued; a requester holds valid and operands until granted. Dropping req_valid before grant is legal.
- Reset mid-operation aborts immediately: mul_start and mul_clr drop, and no response is produced.
- Product width is SIZEA+SIZEB; no truncation.

Test Plan:
- Single request: requester 2 sends a=0x0000FFFF, b=0x00010001; stub core done after 9 cycles -> rsp_id=2, rsp_c=0x00000000FFFFFFFF, rsp_err=0, mul_clr pulses once.
- All 4 requesters valid continuously -> grant order 0,1,2,3,0; each grant only after the previous CLEAR.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_c stable; no new grant until accepted.
- Timeout: core never done, TIMEOUT=16 -> after 16 WAIT cycles rsp_err=1, rsp_c=0, err_sticky=1; next request completes normally with err_sticky still 1.
- Done and timeout in the same cycle -> rsp_err=0, product returned.
- rst low during WAIT -> all outputs 0 asynchronously; after release, requester 1 with a=3, b=5 -> rsp_c=15, and since ptr was reset to 0, requester 0 wins if both are valid.
